// File: rtl/pong_renderer.sv
// pong_renderer
//   Pixel renderer for the Pong video path: N paddles, one ball and an optional
//   dashed centre net. Object positions are shadowed on frame_start so a frame
//   never tears. A small FSM (PLAY / FLASH / OVER) selects the colour scheme.
//
//   Optional feature: define PONG_NET_EN to draw the dashed centre net.
//
// Ports
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   pos_h_i        current pixel column
//   pos_v_i        current pixel row (0 = top)
//   blank_i        high outside the visible area
//   frame_start_i  1-cycle pulse at start of vertical blank
//   paddle_y_i     paddle i bottom y at [10*i +: 10]
//   ball_x_i       ball left x
//   ball_y_i       ball bottom y
//   collision_i    1-cycle pulse, ball hit a paddle
//   game_over_i    level, game finished
//   red_o/green_o/blue_o  registered pixel colour (2 clk after pos/blank)
//   flashing_o     high while the FSM is in FLASH
module pong_renderer #(
    parameter int unsigned N_PADDLES    = 2,
    parameter int unsigned PADDLE_X0    = 64,
    parameter int unsigned PADDLE_PITCH = 512,
    parameter int unsigned PADDLE_W     = 1,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned BALL_W       = 3,
    parameter int unsigned BALL_H       = 3,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned COLOR_W      = 1,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [9:0]              pos_h_i,
    input  logic [9:0]              pos_v_i,
    input  logic                    blank_i,
    input  logic                    frame_start_i,
    input  logic [10*N_PADDLES-1:0] paddle_y_i,
    input  logic [9:0]              ball_x_i,
    input  logic [9:0]              ball_y_i,
    input  logic                    collision_i,
    input  logic                    game_over_i,
    output logic [COLOR_W-1:0]      red_o,
    output logic [COLOR_W-1:0]      green_o,
    output logic [COLOR_W-1:0]      blue_o,
    output logic                    flashing_o
);

    localparam logic [COLOR_W-1:0] Full = {COLOR_W{1'b1}};

    typedef enum logic [1:0] {StPlay, StFlash, StOver} state_e;

    // ---------------------------------------------------------------
    // Frame-synchronous shadow positions
    // ---------------------------------------------------------------
    logic [10*N_PADDLES-1:0] paddle_y_q;
    logic [9:0]              ball_x_q;
    logic [9:0]              ball_y_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddle_y_q <= '0;
            ball_x_q   <= '0;
            ball_y_q   <= '0;
        end else if (frame_start_i) begin
            paddle_y_q <= paddle_y_i;
            ball_x_q   <= ball_x_i;
            ball_y_q   <= ball_y_i;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: hit tests in bottom-left coordinates, 11-bit sums
    // ---------------------------------------------------------------
    logic [10:0]          x;
    logic [10:0]          y;
    logic [N_PADDLES-1:0] paddle_hit_d;
    logic [N_PADDLES-1:0] paddle_hit_q;
    logic                 ball_hit_d;
    logic                 ball_hit_q;
    logic                 blank_q;
    logic                 net_draw;

    assign x = {1'b0, pos_h_i};
    assign y = 11'(SCREEN_H) - {1'b0, pos_v_i};

    always_comb begin
        paddle_hit_d = '0;
        for (int i = 0; i < N_PADDLES; i++) begin
            paddle_hit_d[i] = (x >= 11'(PADDLE_X0 + i * PADDLE_PITCH)) &&
                              (x <  11'(PADDLE_X0 + i * PADDLE_PITCH + PADDLE_W)) &&
                              (y >= {1'b0, paddle_y_q[10*i +: 10]}) &&
                              (y <  {1'b0, paddle_y_q[10*i +: 10]} + 11'(PADDLE_H));
        end
    end

    assign ball_hit_d = (x >= {1'b0, ball_x_q}) && (x < {1'b0, ball_x_q} + 11'(BALL_W)) &&
                        (y >= {1'b0, ball_y_q}) && (y < {1'b0, ball_y_q} + 11'(BALL_H));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddle_hit_q <= '0;
            ball_hit_q   <= 1'b0;
            blank_q      <= 1'b1;  // keeps the first post-reset pixel black
        end else begin
            paddle_hit_q <= paddle_hit_d;
            ball_hit_q   <= ball_hit_d;
            blank_q      <= blank_i;
        end
    end

`ifdef PONG_NET_EN
    // Dashed net: two columns at screen centre, lit where y[3] is clear.
    logic net_hit_d;
    logic net_hit_q;

    assign net_hit_d = (x >= 11'(SCREEN_W / 2 - 1)) && (x <= 11'(SCREEN_W / 2)) && !y[3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            net_hit_q <= 1'b0;
        end else begin
            net_hit_q <= net_hit_d;
        end
    end

    assign net_draw = net_hit_q;
`else
    assign net_draw = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Game-state FSM
    // ---------------------------------------------------------------
    state_e     state_q;
    logic [7:0] flash_cnt_q;
    logic       flashing_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StPlay;
            flash_cnt_q <= '0;
            flashing_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (game_over_i) begin
                        state_q <= StOver;
                    end else if (collision_i) begin
                        state_q     <= StFlash;
                        flash_cnt_q <= 8'(FLASH_FRAMES);
                        flashing_q  <= 1'b1;
                    end
                end
                StFlash: begin
                    if (game_over_i) begin
                        state_q     <= StOver;
                        flash_cnt_q <= '0;
                        flashing_q  <= 1'b0;
                    end else if (collision_i) begin
                        flash_cnt_q <= 8'(FLASH_FRAMES);
                    end else if (frame_start_i) begin
                        // Count of 1 means this frame_start is the last flash frame.
                        if (flash_cnt_q <= 8'd1) begin
                            state_q     <= StPlay;
                            flash_cnt_q <= '0;
                            flashing_q  <= 1'b0;
                        end else begin
                            flash_cnt_q <= flash_cnt_q - 8'd1;
                        end
                    end
                end
                StOver: begin
                    if (frame_start_i && !game_over_i) begin
                        state_q <= StPlay;
                    end
                end
                default: begin
                    state_q     <= StPlay;
                    flash_cnt_q <= '0;
                    flashing_q  <= 1'b0;
                end
            endcase
        end
    end

    assign flashing_o = flashing_q;

    // ---------------------------------------------------------------
    // Stage 2: colour selection
    // ---------------------------------------------------------------
    logic [COLOR_W-1:0] red_d, green_d, blue_d;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               obj_hit;
    logic               left_lost;

    assign obj_hit   = ball_hit_q || (|paddle_hit_q);
    assign left_lost = ball_x_q < 10'(SCREEN_W / 2);

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (blank_q) begin
            // black outside the visible area in every state
        end else if (state_q == StOver) begin
            if (left_lost) begin
                if (obj_hit) begin
                    green_d = Full;
                    blue_d  = Full;
                end else begin
                    red_d = Full;
                end
            end else begin
                if (obj_hit) begin
                    red_d  = Full;
                    blue_d = Full;
                end else begin
                    green_d = Full;
                end
            end
        end else if (ball_hit_q) begin
            red_d   = Full;
            green_d = Full;
            blue_d  = (state_q == StFlash) ? '0 : Full;
        end else if (paddle_hit_q[0]) begin
            red_d  = Full;
            blue_d = Full;
        end else if (|paddle_hit_q) begin
            green_d = Full;
            blue_d  = Full;
        end else if (net_draw) begin
            // Half scale = MSB only, which is full scale when COLOR_W is 1.
            red_d   = COLOR_W'(1) << (COLOR_W - 1);
            green_d = COLOR_W'(1) << (COLOR_W - 1);
            blue_d  = COLOR_W'(1) << (COLOR_W - 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red_o   = red_q;
    assign green_o = green_q;
    assign blue_o  = blue_q;

endmodule

// File: tb/tb_pong_renderer.sv
// Testbench for pong_renderer: table-driven pixel vectors fed through a
// scoreboard queue (expected RGB popped two clocks after drive), plus
// hand-written sequences for flash, game-over and mid-frame reset.
`timescale 1ns/1ps
module tb_pong_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pos_h, pos_v;
    logic        blank, frame_start;
    logic [19:0] paddle_y;
    logic [9:0]  ball_x, ball_y;
    logic        collision, game_over;
    logic [0:0]  red, green, blue;
    logic        flashing;

    always #5 clk = ~clk;

    pong_renderer #(
        .FLASH_FRAMES(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pos_h_i      (pos_h),
        .pos_v_i      (pos_v),
        .blank_i      (blank),
        .frame_start_i(frame_start),
        .paddle_y_i   (paddle_y),
        .ball_x_i     (ball_x),
        .ball_y_i     (ball_y),
        .collision_i  (collision),
        .game_over_i  (game_over),
        .red_o        (red),
        .green_o      (green),
        .blue_o       (blue),
        .flashing_o   (flashing)
    );

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       bl;
        logic [2:0] rgb;
        string      name;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] rgb;
        string      name;
    } exp_t;

    exp_t sbq[$];
    vec_t play_tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic [2:0] net_rgb;

    // Advance one clock; compare every scoreboard entry that is due.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            n_cmp++;
            if ({red, green, blue} !== e.rgb) begin
                n_bad++;
                $display("FAIL %s: rgb=%b required %b", e.name, {red, green, blue}, e.rgb);
            end
        end
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic bl,
                         input logic [2:0] rgb, input string name);
        exp_t e;
        pos_h = h;
        pos_v = v;
        blank = bl;
        e.due  = cyc + 2;
        e.rgb  = rgb;
        e.name = name;
        sbq.push_back(e);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic fs();
        frame_start = 1'b1;
        blank       = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PONG_NET_EN
        net_rgb = 3'b111;
`else
        net_rgb = 3'b000;
`endif
        // paddle0 x=64 y[100,164); paddle1 x=576 y[200,264); ball x[300,303) y[50,53)
        play_tbl.push_back('{10'd64,  10'd360, 1'b0, 3'b101, "p0_hit"});
        play_tbl.push_back('{10'd65,  10'd360, 1'b0, 3'b000, "p0_right_edge"});
        play_tbl.push_back('{10'd64,  10'd360, 1'b1, 3'b000, "p0_blanked"});
        play_tbl.push_back('{10'd64,  10'd381, 1'b0, 3'b000, "p0_below"});
        play_tbl.push_back('{10'd64,  10'd317, 1'b0, 3'b101, "p0_top_row"});
        play_tbl.push_back('{10'd64,  10'd316, 1'b0, 3'b000, "p0_above"});
        play_tbl.push_back('{10'd576, 10'd230, 1'b0, 3'b011, "p1_hit"});
        play_tbl.push_back('{10'd575, 10'd230, 1'b0, 3'b000, "p1_left_edge"});
        play_tbl.push_back('{10'd300, 10'd430, 1'b0, 3'b111, "ball_bl"});
        play_tbl.push_back('{10'd302, 10'd428, 1'b0, 3'b111, "ball_tr"});
        play_tbl.push_back('{10'd303, 10'd430, 1'b0, 3'b000, "ball_right_out"});
        play_tbl.push_back('{10'd300, 10'd427, 1'b0, 3'b000, "ball_top_out"});
        play_tbl.push_back('{10'd100, 10'd240, 1'b0, 3'b000, "background"});
        play_tbl.push_back('{10'd320, 10'd464, 1'b0, net_rgb, "net_320"});
        play_tbl.push_back('{10'd319, 10'd464, 1'b0, net_rgb, "net_319"});
        play_tbl.push_back('{10'd320, 10'd472, 1'b0, 3'b000, "net_gap"});
        play_tbl.push_back('{10'd318, 10'd464, 1'b0, 3'b000, "net_left_out"});

        rst_n = 1'b0;
        pos_h = '0; pos_v = '0; blank = 1'b1; frame_start = 1'b0;
        paddle_y = '0; ball_x = '0; ball_y = '0; collision = 1'b0; game_over = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rgb", 32'({red, green, blue}), 32'd0);
        check("reset_flashing", 32'(flashing), 32'd0);
        rst_n = 1'b1;

        paddle_y = {10'd200, 10'd100};
        ball_x   = 10'd300;
        ball_y   = 10'd50;
        fs();

        // PLAY colours, streamed one pixel per clock
        foreach (play_tbl[i]) drive(play_tbl[i].h, play_tbl[i].v, play_tbl[i].bl,
                                    play_tbl[i].rgb, play_tbl[i].name);
        drain();

        // Shadowing: new ball_x only takes effect after frame_start
        ball_x = 10'd400;
        drive(10'd300, 10'd430, 1'b0, 3'b111, "shadow_old_pos");
        drive(10'd400, 10'd430, 1'b0, 3'b000, "shadow_new_not_yet");
        drain();
        fs();
        drive(10'd400, 10'd430, 1'b0, 3'b111, "shadow_new_pos");
        drive(10'd300, 10'd430, 1'b0, 3'b000, "shadow_old_gone");
        drain();

        // Collision flash, FLASH_FRAMES = 2
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("flash_enter", 32'(flashing), 32'd1);
        drive(10'd400, 10'd430, 1'b0, 3'b110, "flash_ball_yellow");
        drive(10'd64,  10'd360, 1'b0, 3'b101, "flash_paddle");
        drain();
        fs();
        check("flash_after_fs1", 32'(flashing), 32'd1);
        fs();
        check("flash_after_fs2", 32'(flashing), 32'd0);
        drive(10'd400, 10'd430, 1'b0, 3'b111, "ball_after_flash");
        drain();

        // Game over, left player lost
        ball_x = 10'd10;
        fs();
        game_over = 1'b1;
        tick();
        check("over_left_flashing", 32'(flashing), 32'd0);
        drive(10'd100, 10'd240, 1'b0, 3'b100, "over_left_bg");
        drive(10'd64,  10'd360, 1'b0, 3'b011, "over_left_paddle");
        drive(10'd10,  10'd430, 1'b0, 3'b011, "over_left_ball");
        drive(10'd100, 10'd240, 1'b1, 3'b000, "over_left_blank");
        drive(10'd320, 10'd464, 1'b0, 3'b100, "over_no_net");
        drain();
        game_over = 1'b0;
        tick();
        drive(10'd100, 10'd240, 1'b0, 3'b100, "over_hold");
        drain();
        fs();
        drive(10'd100, 10'd240, 1'b0, 3'b000, "over_exit_bg");
        drive(10'd64,  10'd360, 1'b0, 3'b101, "over_exit_paddle");
        drain();

        // Game over, right player lost
        ball_x = 10'd400;
        fs();
        game_over = 1'b1;
        tick();
        drive(10'd100, 10'd240, 1'b0, 3'b010, "over_right_bg");
        drive(10'd400, 10'd430, 1'b0, 3'b101, "over_right_ball");
        drive(10'd576, 10'd230, 1'b0, 3'b101, "over_right_paddle1");
        drain();
        game_over = 1'b0;
        fs();

        // Simultaneous collision and game_over -> OVER, no flash
        collision = 1'b1;
        game_over = 1'b1;
        tick();
        collision = 1'b0;
        check("simul_flashing", 32'(flashing), 32'd0);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("over_ignores_collision", 32'(flashing), 32'd0);
        drive(10'd100, 10'd240, 1'b0, 3'b010, "simul_over_bg");
        drain();
        game_over = 1'b0;
        fs();

        // Mid-line reset while flashing and drawing a paddle
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check("pre_reset_flashing", 32'(flashing), 32'd1);
        drive(10'd64, 10'd360, 1'b0, 3'b101, "pre_reset_paddle");
        drive(10'd64, 10'd360, 1'b0, 3'b101, "pre_reset_paddle2");
        drain();
        #2 rst_n = 1'b0;
        #1;
        check("midline_reset_rgb", 32'({red, green, blue}), 32'd0);
        check("midline_reset_flashing", 32'(flashing), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // zero shadows: paddle 0 now spans y[0,64)
        pos_h = 10'd64;
        pos_v = 10'd450;
        blank = 1'b0;
        begin
            exp_t e;
            e.due = cyc + 1; e.rgb = 3'b000; e.name = "post_reset_clk1";
            sbq.push_back(e);
            e.due = cyc + 2; e.rgb = 3'b101; e.name = "post_reset_zero_shadow";
            sbq.push_back(e);
        end
        tick();
        tick();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
